// File: rtl/lin_interp_4x_if.sv
// Sample/enable bundle between the 48 kHz scaling stage, the output-rate
// enable and the 4x linear interpolator.
interface lin_interp_4x_if #(
    parameter int unsigned W = 18
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         clken_out;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         underrun;

    modport master (
        output din, din_valid, clken_out,
        input  dout, dout_valid, underrun
    );

    modport slave (
        input  din, din_valid, clken_out,
        output dout, dout_valid, underrun
    );
endinterface

// File: rtl/lin_interp_4x.sv
// Linear interpolator raising a 48 kHz scaled stereo component to 4x rate:
// emits prev + floor(k*(cur-prev)/N) for k = 0..N-1 on successive output ticks.
module lin_interp_4x #(
    parameter int unsigned W     = 18,
    parameter int unsigned LOG2N = 2
) (
    input  logic             clock,
    input  logic             reset,
    lin_interp_4x_if.slave   bus
);
    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned DW = W + 1;
    localparam int unsigned AW = W + LOG2N + 1;
    localparam int unsigned PW = LOG2N + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    cur_q, cur_d;
    logic [DW-1:0]   delta_q, delta_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            underrun_q, underrun_d;

    // State register; reset is synchronous and overrides any strobe in its cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            delta_q      <= '0;
            acc_q        <= '0;
            phase_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            delta_q      <= delta_d;
            acc_q        <= acc_d;
            phase_q      <= phase_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    // Tick is served from the pre-load state; a coincident load then wins.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        delta_d      = delta_q;
        acc_d        = acc_q;
        phase_d      = phase_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        underrun_d   = underrun_q;

        if (bus.clken_out) begin
            dout_valid_d = 1'b1;
            unique case (state_q)
                IDLE: dout_d = '0;
                RUN: begin
                    dout_d  = acc_q[AW-2:LOG2N];
                    acc_d   = acc_q + {{LOG2N{delta_q[DW-1]}}, delta_q};
                    phase_d = phase_q + PW'(1);
                    if (phase_d == PW'(N)) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    dout_d     = cur_q;
                    underrun_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        if (bus.din_valid) begin
            delta_d = {bus.din[W-1], bus.din} - {cur_q[W-1], cur_q};
            acc_d   = {cur_q[W-1], cur_q, LOG2N'(0)};
            cur_d   = bus.din;
            phase_d = '0;
            state_d = RUN;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_lin_interp_4x.sv
// Self-checking bench for lin_interp_4x: directed literal sequences plus
// randomized traffic compared every cycle against a segment-level model.
module tb_lin_interp_4x;
    localparam int unsigned W = 18;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    lin_interp_4x_if #(.W(W)) bus ();

    lin_interp_4x #(.W(W), .LOG2N(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: segment endpoints, ticks emitted in segment, expected outputs.
    bit armed;
    bit started;
    int m_prev, m_cur, m_k;
    int exp_dout;
    int exp_valid;
    int exp_under;

    function automatic int fdiv4(input int x);
        if (x >= 0) return x / 4;
        return -((-x + 3) / 4);
    endfunction

    function automatic int sdout();
        return int'($signed(bus.dout));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model evaluated on each rising edge from the sampled inputs.
    initial begin
        armed = 0; started = 0;
        m_prev = 0; m_cur = 0; m_k = 0;
        exp_dout = 0; exp_valid = 0; exp_under = 0;
        forever begin
            @(posedge clock);
            if (reset) begin
                armed = 1; started = 0;
                m_prev = 0; m_cur = 0; m_k = 0;
                exp_dout = 0; exp_valid = 0; exp_under = 0;
            end else begin
                exp_valid = int'(bus.clken_out);
                if (bus.clken_out) begin
                    if (!started) begin
                        exp_dout = 0;
                    end else if (m_k < 4) begin
                        exp_dout = m_prev + fdiv4(m_k * (m_cur - m_prev));
                        m_k++;
                    end else begin
                        exp_dout  = m_cur;
                        exp_under = 1;
                    end
                end
                if (bus.din_valid) begin
                    m_prev  = m_cur;
                    m_cur   = int'($signed(bus.din));
                    m_k     = 0;
                    started = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model once a reset has been seen.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (armed) begin
                chk("cyc_valid", int'(bus.dout_valid), exp_valid);
                chk("cyc_dout", sdout(), exp_dout);
                chk("cyc_underrun", int'(bus.underrun), exp_under);
            end
        end
    end

    task automatic cycle(input logic dv, input int d, input logic ck, input logic rst);
        @(negedge clock);
        bus.din_valid = dv;
        bus.din       = W'(d);
        bus.clken_out = ck;
        reset         = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic tick_lit(input string name, input int exp);
        cycle(1'b0, 0, 1'b1, 1'b0);
        chk({name, "_valid"}, int'(bus.dout_valid), 1);
        chk(name, sdout(), exp);
    endtask

    task automatic load(input int d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.clken_out = 1'b0;

        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        chk("rst_dout", sdout(), 0);
        chk("rst_valid", int'(bus.dout_valid), 0);
        chk("rst_underrun", int'(bus.underrun), 0);

        // Ramp up then down
        cycle(1'b0, 0, 1'b0, 1'b0);
        load(400);
        tick_lit("up_k0", 0);
        tick_lit("up_k1", 100);
        tick_lit("up_k2", 200);
        tick_lit("up_k3", 300);
        load(-400);
        tick_lit("dn_k0", 400);
        tick_lit("dn_k1", 200);
        tick_lit("dn_k2", 0);
        tick_lit("dn_k3", -200);
        chk("dn_no_underrun", int'(bus.underrun), 0);

        // Truncation toward minus infinity
        do_reset();
        load(3);
        tick_lit("tp_k0", 0);
        tick_lit("tp_k1", 0);
        tick_lit("tp_k2", 1);
        tick_lit("tp_k3", 2);
        do_reset();
        load(-3);
        tick_lit("tn_k0", 0);
        tick_lit("tn_k1", -1);
        tick_lit("tn_k2", -2);
        tick_lit("tn_k3", -3);

        // Underrun after the segment runs dry
        do_reset();
        load(400);
        tick_lit("ur_k0", 0);
        tick_lit("ur_k1", 100);
        tick_lit("ur_k2", 200);
        tick_lit("ur_k3", 300);
        chk("ur_before", int'(bus.underrun), 0);
        tick_lit("ur_hold0", 400);
        chk("ur_rise", int'(bus.underrun), 1);
        tick_lit("ur_hold1", 400);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("ur_sticky", int'(bus.underrun), 1);
        chk("ur_dout_held", sdout(), 400);

        // Coincident load and tick at phase 3
        do_reset();
        load(400);
        tick_lit("co_k0", 0);
        tick_lit("co_k1", 100);
        tick_lit("co_k2", 200);
        cycle(1'b1, 800, 1'b1, 1'b0);
        chk("co_tick", sdout(), 300);
        tick_lit("co_n0", 400);
        tick_lit("co_n1", 500);
        tick_lit("co_n2", 600);
        tick_lit("co_n3", 700);

        // Reset mid-segment, with strobes in the reset cycle ignored
        do_reset();
        load(400);
        tick_lit("mr_k0", 0);
        tick_lit("mr_k1", 100);
        cycle(1'b1, 1234, 1'b1, 1'b1);
        chk("mr_dout", sdout(), 0);
        chk("mr_valid", int'(bus.dout_valid), 0);
        chk("mr_underrun", int'(bus.underrun), 0);
        tick_lit("mr_idle_tick", 0);
        chk("mr_idle_underrun", int'(bus.underrun), 0);

        // Full-scale swing: no wrap across the segment
        do_reset();
        load(131071);
        tick_lit("ex_up0", 0);
        tick_lit("ex_up1", 32767);
        tick_lit("ex_up2", 65535);
        tick_lit("ex_up3", 98303);
        load(-131072);
        tick_lit("ex_dn0", 131071);
        tick_lit("ex_dn1", 65535);
        tick_lit("ex_dn2", -1);
        tick_lit("ex_dn3", -65537);
        tick_lit("ex_hold", -131072);

        // Regular cadence with a random input sequence
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            cycle(1'b0 | (i % 16 == 5), int'($urandom_range(0, 262143)) - 131072,
                  1'b0 | (i % 4 == 1), 1'b0);
        end

        // Fully random strobes, including abandoned segments and underruns
        for (int i = 0; i < 4000; i++) begin
            int d;
            logic dv, ck, rst;
            d   = int'($urandom_range(0, 262143)) - 131072;
            if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 0) ? 131071 : -131072;
            dv  = ($urandom_range(0, 15) == 0);
            ck  = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            cycle(dv, d, ck, rst);
        end
        cycle(1'b0, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
